stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Valid/ready buffer stage directly downstream of custom_logic. It consumes custom_logic's down_data/down_valid/down_ready stream.
- Absorbs backpressure bursts from the sink so custom_logic is not stalled by single-cycle sink hiccups.
- First-word-fall-through FIFO, depth 2**A_WIDTH, with occupancy reporting.
- Sits between custom_logic and the top-level down_* ports.

Parameters:
- D_WIDTH, 6, payload width in bits; matches custom_logic.
- A_WIDTH, 2, address width; depth = 2**A_WIDTH entries (default 4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (rst=0 resets on next rising clk edge).
- up_data  input  D_WIDTH  payload from custom_logic.
- up_valid  input  1  upstream payload valid.
- up_ready  output  1  FIFO can accept this cycle.
- down_data  output  D_WIDTH  head-of-FIFO payload.
- down_valid  output  1  FIFO non-empty.
- down_ready  input  1  sink accepts this cycle.
- level  output  A_WIDTH+1  current occupancy, 0 to 2**A_WIDTH.
- almost_full  output  1  level >= 2**A_WIDTH-1.

Behaviour:
- State:
  - wr_ptr, rd_ptr: A_WIDTH bits each, wrap modulo depth.
  - count: A_WIDTH+1 bits.
  - mem: 2**A_WIDTH x D_WIDTH registers, not reset.
- Reset (rst=0 at a clk edge): wr_ptr=0, rd_ptr=0, count=0.
  - While rst=0, up_ready=0 and down_valid=0, combinationally gated.
  - Any up_valid during reset is ignored.
  - Reset mid-operation discards all stored entries; no partial transfer completes.
- Outputs after reset:
  - down_valid=0, down_data=0, level=0, almost_full=0.
  - up_ready=1 in the first cycle with rst=1.
- Handshake definitions:
  - push = up_valid & up_ready.
  - pop = down_valid & down_ready.
- Handshake rules:
  - up_ready = rst & (count != 2**A_WIDTH).
  - up_ready does not depend on up_valid or down_ready; there is no same-cycle pass-through when full.
  - down_valid = rst & (count != 0).
  - down_data = mem[rd_ptr] when down_valid=1, else all zeros.
  - down_data/down_valid stay stable while down_valid=1 and down_ready=0.
- Push: mem[wr_ptr] <= up_data; wr_ptr increments, wrapping from depth-1 to 0.
- Pop: rd_ptr increments with wrap.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or neither.
- Latency: a word pushed at edge N appears on down_data with down_valid=1 from cycle N+1 if the FIFO was empty. Otherwise it appears in order behind older entries.
- Throughput: 1 word/cycle sustained when both sides are ready, including at level 1 and level depth-1.
- Full boundary: up_ready=0. A simultaneous pop this cycle does not allow a push; up_ready returns to 1 the cycle after the pop.
- Empty boundary: down_valid=0, so no pop occurs. A push this cycle makes down_valid=1 next cycle.
- level = count, registered. almost_full is derived combinationally from count.
- Ordering: strict FIFO. No drops, no duplication.

Decomposition:
- Shared package stream_pkg holds:
  - constants D_WIDTH_DEF=6 and A_WIDTH_DEF=2, used by rtl, custom_logic and stream_fifo;
  - localparam function depth(a_width) = 1<<a_width.
- Single module. Storage is a plain register array inside stream_fifo; no sub-module is warranted at this size.
- rtl instantiates stream_fifo after custom_logic. custom_logic.down_* connects to stream_fifo.up_*.

Test Plan:
- Reset hold: rst=0 for 3 cycles with up_valid=1, up_data=6'h2A -> up_ready=0, down_valid=0, level=0. After release, down_valid stays 0 until a push.
- Fill to full with down_ready=0: push 6'h01..6'h04 -> level goes 1,2,3,4. almost_full=1 at level 3. up_ready=0 at level 4. A fifth word 6'h05 held on up_valid is not accepted.
- Drain order: from full, set down_ready=1 -> down_data 01,02,03,04 on consecutive cycles, then down_valid=0. Pending 05 is accepted the cycle after the first pop and emerges after 04.
- Streaming: up_valid=1 and down_ready=1 continuously, data 0..63 incrementing, depth 4 -> every value appears exactly once, in order, one per cycle after 1-cycle latency. level stays 1.
- Pointer wrap and random stalls: 200 words with random up_valid/down_ready (50%) -> scoreboard matches. level is never >4 and never underflows. down_data is stable while stalled.
- Mid-operation reset: level 3, assert rst=0 for 1 cycle -> level=0, down_valid=0. A subsequent push of 6'h3F emerges first, with no stale data.

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_pkg
//  Purpose  : Shared stream widths and the depth helper for the stream path.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int D_WIDTH_DEF = 6;
    localparam int A_WIDTH_DEF = 2;

    function automatic int depth(input int a_width);
        return 1 << a_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo
//  Purpose  : First-word-fall-through valid/ready FIFO with occupancy report.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fifo
    import stream_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [A_WIDTH:0]   level,
    output logic               almost_full
);

    localparam int               c_DEPTH = depth(A_WIDTH);
    localparam logic [A_WIDTH:0] c_FULL  = (A_WIDTH + 1)'(c_DEPTH);
    localparam logic [A_WIDTH:0] c_AFULL = (A_WIDTH + 1)'(c_DEPTH - 1);

    logic [D_WIDTH-1:0] r_mem [c_DEPTH];
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_rd_ptr;
    logic [A_WIDTH:0]   r_count;

    logic w_push;
    logic w_pop;

    // Handshakes are masked while rst is low so nothing transfers in reset.
    assign up_ready    = rst & (r_count != c_FULL);
    assign down_valid  = rst & (r_count != '0);
    assign down_data   = down_valid ? r_mem[r_rd_ptr] : '0;
    assign level       = r_count;
    assign almost_full = (r_count >= c_AFULL);

    assign w_push = up_valid & up_ready;
    assign w_pop  = down_valid & down_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= up_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fifo
//  Purpose  : Directed and scoreboarded checks of the stream_fifo buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data;
    logic       down_valid;
    logic       down_ready;
    logic [2:0] level;
    logic       almost_full;

    int checks   = 0;
    int failures = 0;

    stream_fifo #(.D_WIDTH(6), .A_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .up_data     (up_data),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .down_data   (down_data),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .level       (level),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] q[$];
        logic [5:0] stall_data;
        logic       was_stalled;
        logic       m_push;
        logic       m_pop;
        int         pushed;
        int         cycles;

        rst        = 1'b0;
        up_valid   = 1'b1;
        up_data    = 6'h2A;
        down_ready = 1'b0;

        // Reset hold with traffic offered upstream
        repeat (3) begin
            tick();
            check("rst_up_ready", up_ready, 0);
            check("rst_down_valid", down_valid, 0);
            check("rst_level", level, 0);
        end
        check("rst_down_data", down_data, 0);
        check("rst_almost_full", almost_full, 0);
        rst      = 1'b1;
        up_valid = 1'b0;
        #1;
        check("post_rst_up_ready", up_ready, 1);
        check("post_rst_down_valid", down_valid, 0);
        tick();
        check("idle_down_valid", down_valid, 0);
        check("idle_level", level, 0);

        // Fill to full with the sink stalled
        for (int i = 1; i <= 4; i++) begin
            up_data  = 6'(i);
            up_valid = 1'b1;
            tick();
            check("fill_level", level, i);
            check("fill_almost_full", almost_full, (i >= 3) ? 1 : 0);
            check("fill_up_ready", up_ready, (i < 4) ? 1 : 0);
            check("fill_head", down_data, 6'h01);
        end
        up_data = 6'h05;
        repeat (2) begin
            tick();
            check("full_hold_level", level, 4);
            check("full_hold_head", down_data, 6'h01);
        end

        // Drain; the pending 0x05 enters only once space has opened
        down_ready = 1'b1;
        check("drain_a_data", down_data, 6'h01);
        check("drain_a_up_ready", up_ready, 0);
        tick();
        check("drain_b_data", down_data, 6'h02);
        check("drain_b_up_ready", up_ready, 1);
        check("drain_b_level", level, 3);
        tick();
        up_valid = 1'b0;
        check("drain_c_data", down_data, 6'h03);
        check("drain_c_level", level, 3);
        tick();
        check("drain_d_data", down_data, 6'h04);
        check("drain_d_level", level, 2);
        tick();
        check("drain_e_data", down_data, 6'h05);
        check("drain_e_level", level, 1);
        tick();
        check("drain_f_valid", down_valid, 0);
        check("drain_f_data", down_data, 0);
        check("drain_f_level", level, 0);

        // Continuous streaming at level 1
        up_valid = 1'b1;
        up_data  = 6'h00;
        tick();
        for (int v = 0; v < 64; v++) begin
            check("stream_valid", down_valid, 1);
            check("stream_data", down_data, v);
            check("stream_level", level, 1);
            if (v == 63) up_valid = 1'b0;
            else         up_data  = 6'(v + 1);
            tick();
        end
        check("stream_end_valid", down_valid, 0);
        check("stream_end_level", level, 0);

        // Random stalls on both sides against a queue model
        pushed      = 0;
        cycles      = 0;
        was_stalled = 1'b0;
        stall_data  = '0;
        while ((pushed < 200 || q.size() != 0) && cycles < 3000) begin
            up_valid   = (pushed < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            up_data    = 6'($urandom_range(0, 63));
            down_ready = 1'($urandom_range(0, 1));
            #1;
            check("rnd_level", level, q.size());
            check("rnd_down_valid", down_valid, (q.size() != 0) ? 1 : 0);
            check("rnd_up_ready", up_ready, (q.size() != 4) ? 1 : 0);
            if (q.size() != 0) check("rnd_data", down_data, q[0]);
            if (was_stalled) check("rnd_stall_stable", down_data, stall_data);
            m_push      = up_valid && (q.size() < 4);
            m_pop       = down_ready && (q.size() != 0);
            was_stalled = (q.size() != 0) && !down_ready;
            if (q.size() != 0) stall_data = q[0];
            tick();
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(up_data);
                pushed++;
            end
            cycles++;
        end
        check("rnd_completed", (cycles < 3000) ? 1 : 0, 1);
        up_valid   = 1'b0;
        down_ready = 1'b0;
        #1;

        // Reset while holding three entries
        for (int i = 0; i < 3; i++) begin
            up_valid = 1'b1;
            up_data  = 6'(8'h11 + i);
            tick();
        end
        check("mid_pre_level", level, 3);
        check("mid_pre_almost_full", almost_full, 1);
        rst     = 1'b0;
        up_data = 6'h20;
        #1;
        check("mid_rst_up_ready", up_ready, 0);
        check("mid_rst_down_valid", down_valid, 0);
        tick();
        rst      = 1'b1;
        up_valid = 1'b0;
        #1;
        check("mid_post_level", level, 0);
        check("mid_post_down_valid", down_valid, 0);
        check("mid_post_almost_full", almost_full, 0);
        up_valid = 1'b1;
        up_data  = 6'h3F;
        tick();
        up_valid = 1'b0;
        check("fresh_valid", down_valid, 1);
        check("fresh_data", down_data, 6'h3F);
        check("fresh_level", level, 1);
        down_ready = 1'b1;
        tick();
        check("fresh_drained_valid", down_valid, 0);
        check("fresh_drained_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
